// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter slice.
//   - SZ_B/SZ_H/SZ_W/SZ_D : load/store size encodings (bytes = 1 << size)
//   - arb_state_e          : arbiter FSM state encoding
//   - MEM_BASE_DEFAULT     : physical address mapped to RAM index 0
//   - GRANT_IF/GRANT_LS    : encoding of the last_grant register
package mem_arb_pkg;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for the load/store path.
//   offset     : byte offset of the store/check access (addr[2:0])
//   size       : access size; 4..7 behave as a doubleword
//   wdata      : right-aligned store data
//   rd_offset  : byte offset of the load being returned
//   rdata      : raw 64-bit RAM read data
//   wdata_lane : store data shifted into its byte lanes
//   wmask      : bit-granular write mask covering the accessed bytes
//   rdata_lane : read data shifted right so the addressed byte is at [7:0]
//   misaligned : access is not naturally aligned to its size
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  offset,
    input  logic [2:0]  size,
    input  logic [63:0] wdata,
    input  logic [2:0]  rd_offset,
    input  logic [63:0] rdata,
    output logic [63:0] wdata_lane,
    output logic [63:0] wmask,
    output logic [63:0] rdata_lane,
    output logic        misaligned
);

    logic [2:0] eff_size;
    logic [7:0] size_bytes;
    logic [2:0] low_bits;
    logic [7:0] byte_mask;

    always_comb begin
        eff_size   = (size > SZ_D) ? SZ_D : size;
        size_bytes = 8'hFF;
        low_bits   = 3'b111;
        case (eff_size)
            SZ_B:    begin size_bytes = 8'h01; low_bits = 3'b000; end
            SZ_H:    begin size_bytes = 8'h03; low_bits = 3'b001; end
            SZ_W:    begin size_bytes = 8'h0F; low_bits = 3'b011; end
            default: begin size_bytes = 8'hFF; low_bits = 3'b111; end
        endcase

        // Bytes shifted past lane 7 fall off; only misaligned accesses
        // can do that and those never reach the RAM.
        byte_mask = size_bytes << offset;
        wmask     = '0;
        for (int i = 0; i < 8; i++) begin
            wmask[i*8 +: 8] = {8{byte_mask[i]}};
        end

        misaligned = |(offset & low_bits);
        wdata_lane = wdata << {offset, 3'b000};
        rdata_lane = rdata >> {rd_offset, 3'b000};
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch, load/store) arbiter in front of a
// single-port 64-bit RAM with one cycle of read latency.
//   clock, reset          : clock and synchronous active-high reset
//   if_req/if_addr        : fetch request; if_ready/if_rdata complete it
//   ls_req/ls_wen/ls_addr/ls_size/ls_wdata : load/store request
//   ls_ready/ls_rdata/ls_err               : load/store completion
//   ram_en/ram_idx/ram_wen/ram_wdata/ram_wmask/ram_rdata : RAM port
//
// Handshake: a requester holds req and its fields stable until the cycle
// in which its ready pulses; ready is a single-cycle pulse, data/err are
// valid only in that cycle. Requests are sampled in IDLE only.
//
// Flow: IDLE (grant, register command) -> ISSUE (ram_en) -> RESP (ready).
// A misaligned load/store skips ISSUE and completes with ls_err in RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [63:0] MEM_BASE = MEM_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_wen,
    input  logic [63:0] ls_addr,
    input  logic [2:0]  ls_size,
    input  logic [63:0] ls_wdata,
    output logic        ls_ready,
    output logic [63:0] ls_rdata,
    output logic        ls_err,
    output logic        ram_en,
    output logic [63:0] ram_idx,
    output logic        ram_wen,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    input  logic [63:0] ram_rdata
);

    localparam logic [1:0] ST_IDLE  = ARB_IDLE;
    localparam logic [1:0] ST_ISSUE = ARB_ISSUE;
    localparam logic [1:0] ST_RESP  = ARB_RESP;

    logic [1:0]  state;
    logic        last_grant;
    logic        cmd_is_ls;
    logic        cmd_wen;
    logic        cmd_err;
    logic        cmd_word_hi;
    logic [2:0]  cmd_off;
    logic [63:0] cmd_wmask;
    logic [63:0] ram_idx_q;
    logic [63:0] ram_wdata_q;

    logic        pick_ls;
    logic [63:0] if_idx;
    logic [63:0] ls_idx;
    logic [63:0] lane_wdata;
    logic [63:0] lane_wmask;
    logic [63:0] lane_rdata;
    logic        lane_misaligned;

    mem_lane_align u_align (
        .offset     (ls_addr[2:0]),
        .size       (ls_size),
        .wdata      (ls_wdata),
        .rd_offset  (cmd_off),
        .rdata      (ram_rdata),
        .wdata_lane (lane_wdata),
        .wmask      (lane_wmask),
        .rdata_lane (lane_rdata),
        .misaligned (lane_misaligned)
    );

    // Under contention the requester not granted last time wins; a lone
    // requester always wins.
    always_comb begin
        pick_ls = ls_req && (!if_req || (last_grant == GRANT_IF));
        if_idx  = (if_addr - MEM_BASE) >> 3;
        ls_idx  = (ls_addr - MEM_BASE) >> 3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_grant  <= GRANT_IF;
            cmd_is_ls   <= 1'b0;
            cmd_wen     <= 1'b0;
            cmd_err     <= 1'b0;
            cmd_word_hi <= 1'b0;
            cmd_off     <= 3'd0;
            cmd_wmask   <= '0;
            ram_idx_q   <= '0;
            ram_wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        last_grant <= pick_ls ? GRANT_LS : GRANT_IF;
                        cmd_is_ls  <= pick_ls;
                        if (pick_ls) begin
                            cmd_wen   <= ls_wen;
                            cmd_err   <= lane_misaligned;
                            cmd_off   <= ls_addr[2:0];
                            cmd_wmask <= ls_wen ? lane_wmask : '0;
                            if (lane_misaligned) begin
                                state <= ST_RESP;
                            end else begin
                                state     <= ST_ISSUE;
                                ram_idx_q <= ls_idx;
                                // ram_wdata only moves for stores so it
                                // keeps its last value across fetches/loads.
                                if (ls_wen) begin
                                    ram_wdata_q <= lane_wdata;
                                end
                            end
                        end else begin
                            cmd_wen     <= 1'b0;
                            cmd_err     <= 1'b0;
                            cmd_wmask   <= '0;
                            cmd_word_hi <= if_addr[2];
                            ram_idx_q   <= if_idx;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_en    = (state == ST_ISSUE);
        ram_wen   = ram_en && cmd_wen;
        ram_wmask = ram_wen ? cmd_wmask : '0;
        ram_idx   = ram_idx_q;
        ram_wdata = ram_wdata_q;

        if_ready  = (state == ST_RESP) && !cmd_is_ls;
        ls_ready  = (state == ST_RESP) && cmd_is_ls;
        ls_err    = ls_ready && cmd_err;

        if_rdata  = '0;
        if (if_ready) begin
            if_rdata = cmd_word_hi ? ram_rdata[63:32] : ram_rdata[31:0];
        end
        ls_rdata  = '0;
        if (ls_ready && !cmd_err) begin
            ls_rdata = lane_rdata;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MEM_BASE, 64'h8000_0000, physical address mapped to RAM index 0.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- if_req  in  1  instruction fetch request.
- if_addr  in  64  fetch address; bits [1:0] are ignored.
- if_ready  out  1  one-cycle pulse: the fetch has completed.
- if_rdata  out  32  instruction word; valid only while if_ready=1.
- ls_req  in  1  load/store request.
- ls_wen  in  1  1 = store, 0 = load.
- ls_addr  in  64  byte address.
- ls_size  in  3  access size: 0=B, 1=H, 2=W, 3=D.
- ls_wdata  in  64  store data, right-aligned.
- ls_ready  out  1  one-cycle pulse: the load/store has completed.
- ls_rdata  out  64  load data shifted right by addr[2:0]*8, not extended; valid only while ls_ready=1.
- ls_err  out  1  misaligned access; valid only while ls_ready=1.
- ram_en  out  1  RAM enable.
- ram_idx  out  64  RAM index = (addr - MEM_BASE) >> 3.
- ram_wen  out  1  RAM write enable.
- ram_wdata  out  64  lane-shifted write data.
- ram_wmask  out  64  bit write mask.
- ram_rdata  in  64  RAM read data; valid one cycle after the cycle in which ram_en=1.

Function
REQ-003 A requester holds req and all of its fields stable from assertion until the cycle of its ready pulse.
REQ-004 The FSM has three states: IDLE, ISSUE, RESP.
REQ-005 IDLE with any req pending: the arbiter selects one requester, registers its command, and moves to ISSUE. IDLE with no req pending: the FSM stays in IDLE.
REQ-006 Contention (both req=1 in IDLE): the grant alternates by round-robin. A last_grant register records the winner. The winner is the requester that was not last granted.
REQ-007 With a single requester, that requester is granted immediately; last_grant updates on every grant.
REQ-008 ISSUE: ram_en=1 for exactly one cycle, driven from the registered command; the FSM then moves to RESP.
REQ-009 RESP: the granted requester's ready pulses for one cycle, its rdata is taken from ram_rdata, and the FSM moves to IDLE. Req inputs are ignored during RESP.
REQ-010 Latency is 2 cycles from req sampled in IDLE to ready. Back-to-back throughput is one access every 3 cycles.
REQ-011 if_rdata = ram_rdata[63:32] when if_addr[2]=1, otherwise ram_rdata[31:0].
REQ-012 Fetches are always reads: ram_wen=0.
REQ-013 Store path:
- ram_wdata = ls_wdata << (ls_addr[2:0]*8).
- ram_wmask = the byte mask of (1<<ls_size) bytes starting at byte ls_addr[2:0], expanded to bits.
- ram_wen=1.
REQ-014 Load path: ram_wen=0, ram_wmask=0.
REQ-015 An access is misaligned when (ls_addr[2:0] & ((1<<ls_size)-1)) != 0.
REQ-016 A misaligned LSU grant moves IDLE -> RESP directly: no ram_en; ls_ready=1 with ls_err=1 and ls_rdata=0.
REQ-017 Outside ISSUE: ram_en=0, ram_wen=0, ram_wmask=0. ram_idx and ram_wdata hold their last values.
REQ-018 ls_err=0 on all aligned completions.
REQ-019 ls_size values 4 to 7 are treated as size 3.
REQ-020 Index subtraction wraps modulo 2^64; no range check is performed.

Reset
REQ-021 Reset state:
- FSM = IDLE.
- last_grant = IFU, so the first contention grants the LSU.
- All outputs = 0.
REQ-022 Reset asserted during ISSUE or RESP aborts the access. No ready pulse is produced and ram_en is 0 in the cycle after reset is sampled.
REQ-023 After reset deasserts, a still-held req is re-arbitrated from IDLE.

Structure
REQ-024 Shared package mem_arb_pkg holds:
- the size encodings SZ_B/SZ_H/SZ_W/SZ_D;
- the FSM state enum;
- the MEM_BASE default constant.
REQ-025 Lane shifting, mask generation and the misalignment check live in one combinational sub-module, mem_lane_align. The FSM, grant logic and registers stay in mem_port_arbiter.

Verification
REQ-026 Single fetch:
- Stimulus: if_req=1, if_addr=0x8000_0004; RAM index 0 = 0x1111_2222_3333_4444.
- Required: ram_en in cycle 1 with ram_idx=0; if_ready in cycle 2 with if_rdata=0x1111_2222.
REQ-027 Byte store:
- Stimulus: ls_wen=1, ls_addr=0x8000_0013, size=B, wdata=0xAB.
- Required: ram_idx=2, ram_wdata=0xAB<<24, ram_wmask=0x0000_0000_FF00_0000, then ls_ready, ls_err=0.
REQ-028 Contention after reset:
- Stimulus: if_req and ls_req both held.
- Required: grants are LSU then IFU then LSU; ready pulses in cycles 2, 5, 8.
REQ-029 Misaligned load:
- Stimulus: ls_addr=0x8000_0002, size=W.
- Required: no ram_en; ls_ready with ls_err=1 in cycle 1.
REQ-030 Reset mid-access:
- Stimulus: reset asserted in the ISSUE cycle.
- Required: no ready pulse; FSM in IDLE; a held req is granted again after release.
REQ-031 Halfword load:
- Stimulus: ls_addr=0x8000_000E, size=H; RAM index 1 = 0xBEEF_0000_0000_0000.
- Required: ls_rdata[15:0]=0xBEEF.
